// File: rtl/mdc_pkg.sv
// Shared definitions for the multi-digit up/down counter.
//   DIGIT_W   : width of one BCD/hex digit
//   DEC_MAX   : largest digit value in decimal mode
//   HEX_MAX   : largest digit value in hex mode
//   digit_t   : one digit
//   digit_max : largest legal digit value for the given mode select
package mdc_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DEC_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] HEX_MAX = 4'hF;

  typedef logic [DIGIT_W-1:0] digit_t;

  function automatic digit_t digit_max(input logic sel);
    return sel ? DEC_MAX : HEX_MAX;
  endfunction

endpackage

// File: rtl/mdc_digit.sv
// One digit cell of the counter: computes the stepped value of a single digit.
//   sel        in  1 = decimal (max 9), 0 = hex (max F)
//   dir        in  1 = up, 0 = down
//   cin        in  step request from the previous digit (or the count enable)
//   value      in  current digit value
//   next_value out digit value after the step (unchanged when cin is low)
//   cout       out this digit is at its terminal value and cin is high
module mdc_digit
  import mdc_pkg::*;
(
  input  logic               sel,
  input  logic               dir,
  input  logic               cin,
  input  logic [DIGIT_W-1:0] value,
  output logic [DIGIT_W-1:0] next_value,
  output logic               cout
);

  digit_t max_v;
  digit_t eff_v;
  logic   at_term;

  always_comb begin
    max_v = digit_max(sel);
    // A-F left over from hex mode is treated as 9 in decimal mode.
    eff_v = (value > max_v) ? max_v : value;
    at_term = dir ? (eff_v == max_v) : (eff_v == '0);
    next_value = value;
    if (cin) begin
      if (at_term) begin
        next_value = dir ? '0 : max_v;
      end else begin
        next_value = dir ? (eff_v + 4'd1) : (eff_v - 4'd1);
      end
    end
    cout = cin & at_term;
  end

endmodule

// File: rtl/mdc_counter.sv
// Multi-digit cascadable up/down counter, decimal or hex per digit mode.
//   DIGITS     : number of 4-bit digits (1-8)
//   WRAP       : 1 = wrap at terminal count, 0 = saturate
//   mdc_clk    in  clock, rising edge
//   mdc_rst_n  in  synchronous active-low reset, highest priority
//   mdc_sel    in  1 = decimal, 0 = hex
//   mdc_en     in  count enable
//   mdc_dir    in  1 = up, 0 = down
//   mdc_clr    in  synchronous clear
//   mdc_load   in  parallel load strobe
//   mdc_d      in  load value, digit k at [4k+3:4k]
//   mdc_q      out registered count
//   mdc_tc     out combinational terminal count for cascading
//   mdc_ovf    out sticky wrap/saturate flag
module mdc_counter
  import mdc_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                    mdc_clk,
  input  logic                    mdc_rst_n,
  input  logic                    mdc_sel,
  input  logic                    mdc_en,
  input  logic                    mdc_dir,
  input  logic                    mdc_clr,
  input  logic                    mdc_load,
  input  logic [DIGIT_W*DIGITS-1:0] mdc_d,
  output logic [DIGIT_W*DIGITS-1:0] mdc_q,
  output logic                    mdc_tc,
  output logic                    mdc_ovf
);

  logic [DIGIT_W*DIGITS-1:0] q_q, q_d;
  logic [DIGIT_W*DIGITS-1:0] step_v;
  logic [DIGIT_W*DIGITS-1:0] load_v;
  logic                      ovf_q, ovf_d;
  logic [DIGITS:0]           carry;
  logic                      term_hit;

  assign carry[0] = mdc_en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    mdc_digit u_digit (
      .sel        (mdc_sel),
      .dir        (mdc_dir),
      .cin        (carry[k]),
      .value      (q_q[DIGIT_W*k +: DIGIT_W]),
      .next_value (step_v[DIGIT_W*k +: DIGIT_W]),
      .cout       (carry[k+1])
    );
  end

  // The step request survives the whole chain only when enabled and every
  // digit is terminal; the chain's own result is then the wrapped value.
  assign term_hit = carry[DIGITS];

  always_comb begin
    load_v = mdc_d;
    if (mdc_sel) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (mdc_d[DIGIT_W*k +: DIGIT_W] > DEC_MAX) begin
          load_v[DIGIT_W*k +: DIGIT_W] = DEC_MAX;
        end
      end
    end
  end

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (mdc_clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (mdc_load) begin
      q_d = load_v;
    end else if (term_hit) begin
      ovf_d = 1'b1;
      if (WRAP) begin
        q_d = step_v;
      end
    end else if (mdc_en) begin
      q_d = step_v;
    end
  end

  always_ff @(posedge mdc_clk) begin
    if (!mdc_rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign mdc_q   = q_q;
  assign mdc_ovf = ovf_q;
  assign mdc_tc  = term_hit & ~mdc_clr & ~mdc_load;

endmodule

// File: tb/tb_mdc_counter.sv
module tb_mdc_counter;

  localparam int unsigned D = 2;

  logic       clk = 1'b0;
  logic       rst_n, sel, en, dir, clr, load;
  logic [7:0] d;
  logic [7:0] q_w, q_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int tests  = 0;
  int failed = 0;

  logic [7:0] mq_w, mq_s;
  bit         movf_w, movf_s;

  always #5 clk = ~clk;

  mdc_counter #(.DIGITS(D), .WRAP(1'b1)) u_wrap (
    .mdc_clk(clk), .mdc_rst_n(rst_n), .mdc_sel(sel), .mdc_en(en),
    .mdc_dir(dir), .mdc_clr(clr), .mdc_load(load), .mdc_d(d),
    .mdc_q(q_w), .mdc_tc(tc_w), .mdc_ovf(ovf_w)
  );

  mdc_counter #(.DIGITS(D), .WRAP(1'b0)) u_sat (
    .mdc_clk(clk), .mdc_rst_n(rst_n), .mdc_sel(sel), .mdc_en(en),
    .mdc_dir(dir), .mdc_clr(clr), .mdc_load(load), .mdc_d(d),
    .mdc_q(q_s), .mdc_tc(tc_s), .mdc_ovf(ovf_s)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int dmax(input bit s);
    return s ? 9 : 15;
  endfunction

  // Whole-number view: terminal means the count is at its top (up) or zero (down).
  function automatic bit m_term(input logic [7:0] q, input bit up, input bit s);
    for (int k = 0; k < D; k++) begin
      int v;
      v = int'(q[4*k +: 4]);
      if (v > dmax(s)) v = dmax(s);
      if (up ? (v != dmax(s)) : (v != 0)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Add or subtract one, propagating from the least significant digit;
  // digits above the first one that absorbs the step keep their raw value.
  function automatic logic [7:0] m_count(input logic [7:0] q, input bit up, input bit s);
    logic [7:0] r;
    r = q;
    for (int k = 0; k < D; k++) begin
      int v;
      v = int'(q[4*k +: 4]);
      if (v > dmax(s)) v = dmax(s);
      if (up) begin
        if (v == dmax(s)) r[4*k +: 4] = 4'd0;
        else begin r[4*k +: 4] = 4'(v + 1); break; end
      end else begin
        if (v == 0) r[4*k +: 4] = 4'(dmax(s));
        else begin r[4*k +: 4] = 4'(v - 1); break; end
      end
    end
    return r;
  endfunction

  function automatic void m_next(input bit wrap, input logic [7:0] q, input bit ovf,
                                 output logic [7:0] nq, output bit novf);
    nq = q;
    novf = ovf;
    if (!rst_n || clr) begin
      nq = 8'h00;
      novf = 1'b0;
    end else if (load) begin
      for (int k = 0; k < D; k++) begin
        nq[4*k +: 4] = (sel && d[4*k +: 4] > 4'd9) ? 4'd9 : d[4*k +: 4];
      end
    end else if (en) begin
      if (m_term(q, dir, sel)) begin
        novf = 1'b1;
        if (wrap) nq = dir ? 8'h00 : (sel ? 8'h99 : 8'hFF);
      end else begin
        nq = m_count(q, dir, sel);
      end
    end
  endfunction

  task automatic step(input bit r, input bit c, input bit l, input bit e,
                      input bit up, input bit s, input logic [7:0] dv);
    logic [7:0] nq;
    bit         no;
    rst_n = r; clr = c; load = l; en = e; dir = up; sel = s; d = dv;
    #1;
    check("tc_wrap", {7'd0, tc_w}, {7'd0, e & ~c & ~l & m_term(mq_w, up, s)});
    check("tc_sat",  {7'd0, tc_s}, {7'd0, e & ~c & ~l & m_term(mq_s, up, s)});
    @(posedge clk);
    m_next(1'b1, mq_w, movf_w, nq, no); mq_w = nq; movf_w = no;
    m_next(1'b0, mq_s, movf_s, nq, no); mq_s = nq; movf_s = no;
    #1;
    check("q_wrap",   q_w, mq_w);
    check("ovf_wrap", {7'd0, ovf_w}, {7'd0, movf_w});
    check("q_sat",    q_s, mq_s);
    check("ovf_sat",  {7'd0, ovf_s}, {7'd0, movf_s});
  endtask

  initial begin
    bit rs, rdir;
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b1; sel = 1'b1; d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    mq_w = 8'h00; mq_s = 8'h00; movf_w = 1'b0; movf_s = 1'b0;
    check("reset_q",   q_w, 8'h00);
    check("reset_ovf", {7'd0, ovf_w}, 8'h00);
    check("reset_tc",  {7'd0, tc_w}, 8'h00);

    // Decimal up through the full range.
    for (int i = 0; i < 99; i++) step(1, 0, 0, 1, 1, 1, 8'h00);
    check("dec_99_q", q_w, 8'h99);
    check("dec_99_tc", {7'd0, tc_w}, 8'h01);
    step(1, 0, 0, 1, 1, 1, 8'h00);
    check("dec_wrap_q", q_w, 8'h00);
    check("dec_wrap_ovf", {7'd0, ovf_w}, 8'h01);
    check("dec_sat_q", q_s, 8'h99);
    step(1, 1, 0, 0, 1, 1, 8'h00);
    check("clr_ovf", {7'd0, ovf_w}, 8'h00);

    // Hex carry and terminal.
    step(1, 0, 1, 0, 1, 0, 8'h0F);
    step(1, 0, 0, 1, 1, 0, 8'h00);
    check("hex_carry", q_w, 8'h10);
    step(1, 0, 1, 0, 1, 0, 8'hFF);
    step(1, 0, 0, 1, 1, 0, 8'h00);
    check("hex_wrap_q", q_w, 8'h00);
    check("hex_wrap_ovf", {7'd0, ovf_w}, 8'h01);

    // Decimal down from zero.
    step(1, 1, 0, 0, 0, 1, 8'h00);
    step(1, 0, 0, 1, 0, 1, 8'h00);
    check("down_wrap_q", q_w, 8'h99);
    check("down_sat_q", q_s, 8'h00);
    check("down_sat_ovf", {7'd0, ovf_s}, 8'h01);

    // Priority: load clamps, clear beats load.
    step(1, 0, 1, 1, 1, 1, 8'h5C);
    check("load_clamp", q_w, 8'h59);
    step(1, 1, 1, 1, 1, 1, 8'h5C);
    check("clr_over_load", q_w, 8'h00);

    // Hex digit carried into decimal mode, then reset mid-count.
    step(1, 0, 1, 0, 1, 0, 8'h0B);
    step(1, 0, 0, 1, 1, 1, 8'h00);
    check("mode_switch", q_w, 8'h10);
    step(1, 0, 0, 1, 1, 1, 8'h00);
    step(0, 0, 1, 1, 1, 1, 8'h77);
    check("rst_mid_q", q_w, 8'h00);

    // Randomised stretch against the model.
    rs = 1'b1; rdir = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) rs = ~rs;
      if ($urandom_range(0, 14) == 0) rdir = ~rdir;
      step($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
           rdir, rs, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mdc_counter.md
# mdc_counter

Parametrised multi-digit up/down counter, the successor to the single-digit hex/decimal counter cells. Counts DIGITS cascaded 4-bit digits, each either decimal (0–9) or hex (0–F) under a run-time mode select, with enable, direction, parallel load, clear, wrap/saturate policy and a cascade terminal-count output. It drives the seven-segment display multiplexer directly (one nibble per digit) and chains with further instances through `mdc_tc`.

## Interface
- `DIGITS`, default 2: number of 4-bit digits; legal range 1–8.
- `WRAP`, default 1: 1 = wrap at terminal count; 0 = saturate (hold) at terminal count.
- `mdc_clk`  in  1  single clock; all state changes on its rising edge.
- `mdc_rst_n`  in  1  reset, synchronous, active-low; highest priority.
- `mdc_sel`  in  1  mode: 1 = decimal (digit max 9), 0 = hex (digit max F).
- `mdc_en`  in  1  count enable; one step per cycle while high.
- `mdc_dir`  in  1  1 = up, 0 = down.
- `mdc_clr`  in  1  synchronous clear to 0.
- `mdc_load`  in  1  parallel load strobe.
- `mdc_d`  in  4*DIGITS  load value; digit k at bits [4k+3:4k], digit 0 least significant.
- `mdc_q`  out  4*DIGITS  registered count, same packing as `mdc_d`.
- `mdc_tc`  out  1  combinational terminal count: `mdc_en` high and every digit at its terminal value for the current direction.
- `mdc_ovf`  out  1  sticky registered flag: set on any wrap or saturate event.

## Operation
- Priority per edge: `mdc_rst_n` low > `mdc_clr` > `mdc_load` > `mdc_en` count > hold.
- Reset or clear: `mdc_q` = 0, `mdc_ovf` = 0.
- Load: `mdc_q` = `mdc_d`. In decimal mode, any loaded digit > 9 is clamped to 9. `mdc_ovf` is unchanged.
- Count up: digit 0 increments. A digit at max (9 in decimal, F in hex) becomes 0 and carries into the next digit. Carry ripples combinationally within one cycle.
- Count down: digit 0 decrements. A digit at 0 becomes max and borrows from the next digit.
- Decimal mode with a digit holding A–F (mode switched mid-count): the digit is treated as 9. Up gives 0 with carry; down gives 8.
- Terminal value: up means all digits at max; down means all digits at 0.
- At terminal count with `mdc_en` high:
  - WRAP=1: `mdc_q` wraps to all-0 (up) or all-max (down), and `mdc_ovf` sets.
  - WRAP=0: `mdc_q` holds, and `mdc_ovf` sets.
- `mdc_tc` is suppressed when `mdc_clr` or `mdc_load` is high, so it only reports a genuine count step.
- `mdc_dir` and `mdc_sel` are sampled every edge. Changing them mid-count takes effect on the next step and needs no flush.

## Timing
- Latency: 1 cycle from inputs to `mdc_q` and `mdc_ovf`.
- `mdc_tc` is same-cycle combinational from `mdc_q`, `mdc_en`, `mdc_dir`, `mdc_sel`, `mdc_clr` and `mdc_load`. For cascading, the downstream instance's `mdc_en` is driven by the upstream `mdc_tc`.
- Reset values: `mdc_q` = 0, `mdc_ovf` = 0, `mdc_tc` = 0 (because `mdc_q` = 0 and direction up is not terminal; with `mdc_dir` = 0 and `mdc_en` = 1 it is 1 combinationally).
- Reset mid-count: the next edge with `mdc_rst_n` low forces all state to 0, whatever the other inputs are. Counting resumes on the first edge after release.

## Structure
- Shared package `mdc_pkg`:
  - `DIGIT_W` = 4
  - `DEC_MAX` = 4'd9
  - `HEX_MAX` = 4'hF
  - typedef `digit_t` (4-bit)
  - function `digit_max(sel)`
- Sub-module `mdc_digit`: one digit cell, instantiated DIGITS times via generate.
  - Inputs: `sel`, `dir`, `cin` (step request), value.
  - Outputs: next value, `cout` (this digit at terminal and `cin`).
  - Carry chain: digit 0 `cin` = `mdc_en`; digit k `cin` = digit k-1 `cout`.
- Top level holds the state registers, priority mux, wrap/saturate logic, ovf flag and tc.

## Test plan
- Reset: hold `mdc_rst_n` = 0 for 2 edges with `mdc_en` = 1 → `mdc_q` = 0x00, `mdc_ovf` = 0, `mdc_tc` = 0.
- DIGITS=2, decimal, up, `mdc_en` = 1 for 99 edges → `mdc_q` = 0x99 and `mdc_tc` = 1. Next edge → `mdc_q` = 0x00 and `mdc_ovf` = 1. After `mdc_clr` pulse → `mdc_ovf` = 0.
- Hex mode: load 0x0F, then one up step → 0x10. Load 0xFF, then one up step → 0x00 with `mdc_ovf` = 1.
- Decimal down from 0x00:
  - WRAP=1 → 0x99 with `mdc_ovf` = 1.
  - WRAP=0 → holds 0x00 with `mdc_ovf` = 1.
- Priority: `mdc_load` = 1 with `mdc_d` = 0x5C, decimal, `mdc_en` = 1 → `mdc_q` = 0x59. Then `mdc_clr` = 1 and `mdc_load` = 1 together → 0x00.
- Mode switch: hex count at 0x0B, then switch to decimal and step up → 0x10. `mdc_rst_n` low mid-count → `mdc_q` = 0 on that edge.
